jelly2_img_from_axi4s: RTL and testbench
========================================

Name: jelly2_img_from_axi4s

Overview:
- Source end of the img stream protocol: accepts AXI4-Stream video (tuser = start of frame, tlast = end of line) and produces the img bus.
- img bus outputs are col_first/col_last/row_first/row_last/de/data/valid, qualified by cke.
- Generates row/column framing flags from counters, resynchronises on SOF, and reports framing errors.
- Sits at the input of every img pipeline, feeding delay and filter stages.

Parameters:
- DATA_WIDTH, 24, pixel width of tdata and m_img_data
- X_WIDTH, 12, width of column counter and param_width
- Y_WIDTH, 12, width of row counter and param_height

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cke  in  1  pipeline clock enable; all state holds when 0
- param_width  in  X_WIDTH  pixels per line (>=1), latched at accepted SOF
- param_height  in  Y_WIDTH  lines per frame (>=1), latched at accepted SOF
- s_axi4s_tuser  in  1  start of frame
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tdata  in  DATA_WIDTH  pixel
- s_axi4s_tvalid  in  1  beat valid
- s_axi4s_tready  out  1  = cke (combinational)
- m_img_col_first  out  1  first pixel of line
- m_img_col_last  out  1  last pixel of line
- m_img_row_first  out  1  first line of frame
- m_img_row_last  out  1  last line of frame
- m_img_de  out  1  data enable
- m_img_data  out  DATA_WIDTH  pixel
- m_img_valid  out  1  output beat valid
- err_sof  out  1  1-cycle pulse: SOF accepted while frame incomplete
- err_eol  out  1  1-cycle pulse: tlast position mismatch

Behaviour:
- Reset (reset_n=0, async):
  - all outputs 0, including m_img_data
  - state WAIT_SOF; x=0, y=0; latched width/height 0
- Accept = s_axi4s_tvalid & cke. No state or output changes while cke=0.
- State WAIT_SOF:
  - accepted beat with tuser=0 is discarded; m_img_valid <= 0.
  - accepted beat with tuser=1: latch params, emit it as x=0,y=0, go ACTIVE.
- State ACTIVE:
  - accepted beat with tuser=1: err_sof pulse, relatch params, treat as x=0,y=0 of a new frame.
  - otherwise emit at current x,y.
- Emitted-beat flags, registered on that cke cycle (latency 1 enabled cycle):
  - m_img_valid=1, m_img_de=1, m_img_data=tdata
  - col_first=(x==0); col_last=tlast
  - row_first=(y==0); row_last=(y==height-1)
- Non-accepted enabled cycle: valid, de and all four flags <= 0; m_img_data holds.
- Counter update on emitted beat:
  - tlast=1: x<=0, y<=y+1; if y==height-1, y<=0 and go WAIT_SOF.
  - tlast=0: x<=x+1, saturating at all-ones.
- err_eol pulses (registered, same cycle as the beat) on either:
  - tlast=1 with x!=width-1, or
  - tlast=0 with x==width-1.
  - Line/frame counting still follows tlast.
- Both error pulses can assert together; each lasts one cke-enabled cycle.
- height=1: row_first and row_last both 1 on every pixel. width=1: col_first=col_last=1 when tlast set.
- Width/height changes mid-frame are ignored until the next accepted SOF.

Test Plan:
- Clean frame: width=4, height=3, tdata 0..11, cke=1, tvalid=1.
  - -> 12 valid outputs, 1 cycle after each beat.
  - col_first on data 0,4,8; col_last on 3,7,11; row_first on 0..3; row_last on 8..11; no errors; state returns to WAIT_SOF.
- Pre-SOF junk: 5 beats tuser=0, then the frame from the clean-frame scenario -> first 5 dropped (valid=0), then identical output.
- cke stall: cke=0 for 3 cycles mid-line 1 -> tready=0, outputs frozen; stream resumes with no lost or duplicated pixel.
- Early tlast: width=4, line 0 with tlast on x=2 -> err_eol pulse with that beat; next beat has col_first=1, row_first=0.
- SOF mid-frame: tuser=1 on line 1 x=2 -> err_sof pulse; that beat is output with col_first=row_first=1; y restarts at 0.
- Reset mid-frame: reset_n low at line 1 -> outputs 0 immediately; after release, beats without tuser are discarded until SOF.

Source files
------------

// File: rtl/jelly2_img_from_axi4s.sv
// AXI4-Stream video to img bus source.
// Builds row/column framing from counters, resyncs on SOF.
module jelly2_img_from_axi4s #(
  parameter int DATA_WIDTH = 24,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,

  input  logic [X_WIDTH-1:0]    param_width,
  input  logic [Y_WIDTH-1:0]    param_height,

  input  logic                  s_axi4s_tuser,
  input  logic                  s_axi4s_tlast,
  input  logic [DATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                  s_axi4s_tvalid,
  output logic                  s_axi4s_tready,

  output logic                  m_img_col_first,
  output logic                  m_img_col_last,
  output logic                  m_img_row_first,
  output logic                  m_img_row_last,
  output logic                  m_img_de,
  output logic [DATA_WIDTH-1:0] m_img_data,
  output logic                  m_img_valid,

  output logic                  err_sof,
  output logic                  err_eol
);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [X_WIDTH-1:0]    x_q, x_d;
  logic [Y_WIDTH-1:0]    y_q, y_d;
  logic [X_WIDTH-1:0]    w_q, w_d;
  logic [Y_WIDTH-1:0]    h_q, h_d;

  logic                  cf_q, cf_d;
  logic                  cl_q, cl_d;
  logic                  rf_q, rf_d;
  logic                  rl_q, rl_d;
  logic                  de_q, de_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  esof_q, esof_d;
  logic                  eeol_q, eeol_d;

  logic                  accept;
  logic                  sof;
  logic                  emit;
  logic [X_WIDTH-1:0]    cx;
  logic [Y_WIDTH-1:0]    cy;
  logic [X_WIDTH-1:0]    cw;
  logic [Y_WIDTH-1:0]    ch;
  logic                  x_last;
  logic                  y_last;

  assign s_axi4s_tready = cke;

  // Next state: an SOF beat restarts at x=0,y=0 with fresh params.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    cf_d    = cf_q;
    cl_d    = cl_q;
    rf_d    = rf_q;
    rl_d    = rl_q;
    de_d    = de_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    esof_d  = esof_q;
    eeol_d  = eeol_q;

    accept = s_axi4s_tvalid & cke;
    sof    = s_axi4s_tuser;
    emit   = accept & ((state_q == ACTIVE) | sof);
    cx     = sof ? '0 : x_q;
    cy     = sof ? '0 : y_q;
    cw     = sof ? param_width  : w_q;
    ch     = sof ? param_height : h_q;
    x_last = (cx == cw - X_WIDTH'(1));
    y_last = (cy == ch - Y_WIDTH'(1));

    if (cke) begin
      vld_d  = 1'b0;
      de_d   = 1'b0;
      cf_d   = 1'b0;
      cl_d   = 1'b0;
      rf_d   = 1'b0;
      rl_d   = 1'b0;
      esof_d = 1'b0;
      eeol_d = 1'b0;
      if (emit) begin
        w_d    = cw;
        h_d    = ch;
        vld_d  = 1'b1;
        de_d   = 1'b1;
        dat_d  = s_axi4s_tdata;
        cf_d   = (cx == '0);
        cl_d   = s_axi4s_tlast;
        rf_d   = (cy == '0);
        rl_d   = y_last;
        esof_d = sof & (state_q == ACTIVE);
        eeol_d = s_axi4s_tlast ^ x_last;
        unique case (1'b1)
          s_axi4s_tlast: begin
            x_d = '0;
            if (y_last) begin
              y_d     = '0;
              state_d = WAIT_SOF;
            end else begin
              y_d     = cy + Y_WIDTH'(1);
              state_d = ACTIVE;
            end
          end
          default: begin
            x_d     = (&cx) ? cx : cx + X_WIDTH'(1);
            y_d     = cy;
            state_d = ACTIVE;
          end
        endcase
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cf_q    <= 1'b0;
      cl_q    <= 1'b0;
      rf_q    <= 1'b0;
      rl_q    <= 1'b0;
      de_q    <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      esof_q  <= 1'b0;
      eeol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cf_q    <= cf_d;
      cl_q    <= cl_d;
      rf_q    <= rf_d;
      rl_q    <= rl_d;
      de_q    <= de_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      esof_q  <= esof_d;
      eeol_q  <= eeol_d;
    end
  end

  assign m_img_col_first = cf_q;
  assign m_img_col_last  = cl_q;
  assign m_img_row_first = rf_q;
  assign m_img_row_last  = rl_q;
  assign m_img_de        = de_q;
  assign m_img_data      = dat_q;
  assign m_img_valid     = vld_q;
  assign err_sof         = esof_q;
  assign err_eol         = eeol_q;

endmodule

// File: tb/tb_jelly2_img_from_axi4s.sv
// Directed table-driven bench for jelly2_img_from_axi4s.
// Flags packed as {valid,de,cf,cl,rf,rl,err_sof,err_eol}.
module tb_jelly2_img_from_axi4s;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cke;
  logic [11:0] param_width;
  logic [11:0] param_height;
  logic        tuser, tlast, tvalid, tready;
  logic [23:0] tdata;
  logic        cf, cl, rf, rl, de, vld, esof, eeol;
  logic [23:0] dat;

  always #5 clk = ~clk;

  jelly2_img_from_axi4s #(
    .DATA_WIDTH(24),
    .X_WIDTH   (12),
    .Y_WIDTH   (12)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cke            (cke),
    .param_width    (param_width),
    .param_height   (param_height),
    .s_axi4s_tuser  (tuser),
    .s_axi4s_tlast  (tlast),
    .s_axi4s_tdata  (tdata),
    .s_axi4s_tvalid (tvalid),
    .s_axi4s_tready (tready),
    .m_img_col_first(cf),
    .m_img_col_last (cl),
    .m_img_row_first(rf),
    .m_img_row_last (rl),
    .m_img_de       (de),
    .m_img_data     (dat),
    .m_img_valid    (vld),
    .err_sof        (esof),
    .err_eol        (eeol)
  );

  typedef struct {
    logic        cke;
    logic        tv;
    logic        tu;
    logic        tl;
    logic [23:0] data;
    logic [11:0] w;
    logic [11:0] h;
    logic [7:0]  ef;
    logic [23:0] ed;
  } vec_t;

  vec_t        vq[$];
  logic [11:0] cur_w;
  logic [11:0] cur_h;
  logic [23:0] last_d;
  logic [7:0]  last_ef;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [7:0] act_flags();
    return {vld, de, cf, cl, rf, rl, esof, eeol};
  endfunction

  function automatic void px(logic tu, logic tl, int d,
                             logic f_cf, logic f_cl,
                             logic f_rf, logic f_rl,
                             logic f_es, logic f_ee);
    vec_t v;
    v.cke  = 1'b1;
    v.tv   = 1'b1;
    v.tu   = tu;
    v.tl   = tl;
    v.data = 24'(d);
    v.w    = cur_w;
    v.h    = cur_h;
    v.ef   = {2'b11, f_cf, f_cl, f_rf, f_rl, f_es, f_ee};
    v.ed   = 24'(d);
    vq.push_back(v);
    last_d  = 24'(d);
    last_ef = v.ef;
  endfunction

  function automatic void drop(int d);
    vec_t v;
    v.cke  = 1'b1;
    v.tv   = 1'b1;
    v.tu   = 1'b0;
    v.tl   = 1'b0;
    v.data = 24'(d);
    v.w    = cur_w;
    v.h    = cur_h;
    v.ef   = 8'h00;
    v.ed   = last_d;
    vq.push_back(v);
    last_ef = 8'h00;
  endfunction

  function automatic void stall();
    vec_t v;
    v.cke  = 1'b0;
    v.tv   = 1'b1;
    v.tu   = 1'b1;
    v.tl   = 1'b1;
    v.data = 24'hABCDEF;
    v.w    = cur_w;
    v.h    = cur_h;
    v.ef   = last_ef;
    v.ed   = last_d;
    vq.push_back(v);
  endfunction

  function automatic void idle();
    vec_t v;
    v.cke  = 1'b1;
    v.tv   = 1'b0;
    v.tu   = 1'b0;
    v.tl   = 1'b0;
    v.data = 24'h123456;
    v.w    = cur_w;
    v.h    = cur_h;
    v.ef   = 8'h00;
    v.ed   = last_d;
    vq.push_back(v);
    last_ef = 8'h00;
  endfunction

  task automatic check(string nm, logic [7:0] af, logic [7:0] ef,
                       logic [23:0] ad, logic [23:0] ed,
                       logic at, logic et);
    checks++;
    if (af !== ef || ad !== ed || at !== et) begin
      failures++;
      $display("FAIL %s: flags=%b data=%0d tready=%b, want flags=%b data=%0d tready=%b",
               nm, af, ad, at, ef, ed, et);
    end
  endtask

  task automatic apply(vec_t v, string nm);
    logic at;
    cke          = v.cke;
    tvalid       = v.tv;
    tuser        = v.tu;
    tlast        = v.tl;
    tdata        = v.data;
    param_width  = v.w;
    param_height = v.h;
    #1;
    at = tready;
    @(posedge clk);
    #1;
    check(nm, act_flags(), v.ef, dat, v.ed, at, v.cke);
  endtask

  task automatic run_queue(string tag);
    for (int i = 0; i < vq.size(); i++)
      apply(vq[i], $sformatf("%s%0d", tag, i));
    vq.delete();
  endtask

  initial begin
    reset_n      = 1'b0;
    cke          = 1'b1;
    tvalid       = 1'b0;
    tuser        = 1'b0;
    tlast        = 1'b0;
    tdata        = '0;
    param_width  = 12'd4;
    param_height = 12'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset", act_flags(), 8'h00, dat, 24'd0, 1'b1, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    last_d  = 24'd0;
    last_ef = 8'h00;
    cur_w   = 12'd4;
    cur_h   = 12'd3;

    // junk before SOF
    for (int i = 0; i < 5; i++) drop(200 + i);
    // clean 4x3 frame with a stall after pixel 5
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        px((y == 0 && x == 0), (x == 3), y * 4 + x,
           (x == 0), (x == 3), (y == 0), (y == 2), 1'b0, 1'b0);
        if (y * 4 + x == 5) begin
          stall();
          stall();
          stall();
        end
      end
    idle();
    drop(300);

    // early tlast, SOF mid-frame, late tlast
    px(1, 0, 100, 1, 0, 1, 0, 0, 0);
    px(0, 0, 101, 0, 0, 1, 0, 0, 0);
    px(0, 1, 102, 0, 1, 1, 0, 0, 1);
    px(0, 0, 103, 1, 0, 0, 0, 0, 0);
    px(0, 0, 104, 0, 0, 0, 0, 0, 0);
    px(1, 0, 105, 1, 0, 1, 0, 1, 0);
    cur_w = 12'd2;
    cur_h = 12'd1;
    px(0, 0, 106, 0, 0, 1, 0, 0, 0);
    px(0, 0, 107, 0, 0, 1, 0, 0, 0);
    px(0, 1, 108, 0, 1, 1, 0, 0, 0);
    px(0, 0, 109, 1, 0, 0, 0, 0, 0);
    px(0, 0, 110, 0, 0, 0, 0, 0, 0);
    px(0, 0, 111, 0, 0, 0, 0, 0, 0);
    px(0, 0, 112, 0, 0, 0, 0, 0, 1);
    px(0, 1, 113, 0, 1, 0, 0, 0, 1);
    px(0, 0, 114, 1, 0, 0, 1, 0, 0);
    px(0, 0, 115, 0, 0, 0, 1, 0, 0);
    px(0, 0, 116, 0, 0, 0, 1, 0, 0);
    px(0, 1, 117, 0, 1, 0, 1, 0, 0);
    drop(400);

    // width 1, height 2: both errors together
    cur_w = 12'd1;
    cur_h = 12'd2;
    px(1, 1, 500, 1, 1, 1, 0, 0, 0);
    px(1, 0, 501, 1, 0, 1, 0, 1, 1);
    px(0, 1, 502, 0, 1, 1, 0, 0, 1);
    px(0, 1, 503, 1, 1, 0, 1, 0, 0);
    drop(504);

    // 1x1 frame
    cur_h = 12'd1;
    px(1, 1, 600, 1, 1, 1, 1, 0, 0);
    drop(601);

    run_queue("vec");

    // reset in the middle of line 1
    cur_w = 12'd4;
    cur_h = 12'd3;
    px(1, 0, 700, 1, 0, 1, 0, 0, 0);
    px(0, 0, 701, 0, 0, 1, 0, 0, 0);
    px(0, 0, 702, 0, 0, 1, 0, 0, 0);
    px(0, 1, 703, 0, 1, 1, 0, 0, 0);
    px(0, 0, 704, 1, 0, 0, 0, 0, 0);
    run_queue("pre_rst");

    reset_n = 1'b0;
    #1;
    check("rst_async", act_flags(), 8'h00, dat, 24'd0, tready, cke);
    tuser = 1'b1;
    tdata = 24'd999;
    @(posedge clk);
    #1;
    check("rst_hold", act_flags(), 8'h00, dat, 24'd0, tready, cke);
    @(negedge clk);
    reset_n = 1'b1;

    last_d  = 24'd0;
    last_ef = 8'h00;
    drop(705);
    drop(706);
    px(1, 0, 707, 1, 0, 1, 0, 0, 0);
    px(0, 0, 708, 0, 0, 1, 0, 0, 0);
    run_queue("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
